// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encodings, ASCII glyph constants,
// and the geometry of one board print.
package ttt_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10,
        CELL_BAD   = 2'b11
    } cell_t;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_PIPE       = 8'h7C;
    localparam logic [7:0] ASCII_DASH       = 8'h2D;
    localparam logic [7:0] ASCII_PLUS       = 8'h2B;
    localparam logic [7:0] ASCII_GT         = 8'h3E;
    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_X_UP       = 8'h58;
    localparam logic [7:0] ASCII_O_UP       = 8'h4F;
    localparam logic [7:0] ASCII_X_LO       = 8'h78;
    localparam logic [7:0] ASCII_O_LO       = 8'h6F;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;
    localparam logic [7:0] ASCII_QUESTION   = 8'h3F;

    localparam int PRINT_LEN = 40;
    localparam int IDX_W     = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PRINT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } print_state_t;

endpackage

// File: rtl/board_glyph.sv
// Combinational map from a print byte index plus a board snapshot to the
// ASCII byte at that position: three cell rows, two separators, a turn line.
module board_glyph
    import ttt_pkg::*;
#(
    parameter logic [7:0] EMPTY_CHAR = 8'h2E
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [17:0]      board,
    input  logic [3:0]       cursor,
    input  logic             turn,
    output logic [7:0]       glyph
);

    logic [2:0]       line_no;
    logic [IDX_W-1:0] base;
    logic [2:0]       col;
    logic [3:0]       cell_idx;
    cell_t            code;
    logic             hit;
    logic [7:0]       cell_glyph;

    // Every output line is 7 bytes long except the final 5-byte turn line.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        line_no = 3'd0;
        base    = '0;
        if (idx >= IDX_W'(35)) begin
            line_no = 3'd5; base = IDX_W'(35);
        end else if (idx >= IDX_W'(28)) begin
            line_no = 3'd4; base = IDX_W'(28);
        end else if (idx >= IDX_W'(21)) begin
            line_no = 3'd3; base = IDX_W'(21);
        end else if (idx >= IDX_W'(14)) begin
            line_no = 3'd2; base = IDX_W'(14);
        end else if (idx >= IDX_W'(7)) begin
            line_no = 3'd1; base = IDX_W'(7);
        end
        col      = 3'(idx - base);
        cell_idx = 4'(line_no[2:1]) * 4'd3 + 4'(col[2:1]);
    end

    always_comb begin
        code = CELL_EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (cell_idx == 4'(i)) code = cell_t'(board[2*i +: 2]);
        end
        hit = (cursor == cell_idx);
        case (code)
            CELL_EMPTY: cell_glyph = hit ? ASCII_UNDERSCORE : EMPTY_CHAR;
            CELL_X:     cell_glyph = hit ? ASCII_X_LO : ASCII_X_UP;
            CELL_O:     cell_glyph = hit ? ASCII_O_LO : ASCII_O_UP;
            CELL_BAD:   cell_glyph = ASCII_QUESTION;
            default:    cell_glyph = ASCII_QUESTION;
        endcase
    end

    always_comb begin
        glyph = 8'h00;
        if (line_no == 3'd5) begin
            case (col)
                3'd0:    glyph = ASCII_GT;
                3'd1:    glyph = ASCII_SPACE;
                3'd2:    glyph = turn ? ASCII_O_UP : ASCII_X_UP;
                3'd3:    glyph = ASCII_CR;
                default: glyph = ASCII_LF;
            endcase
        end else if (col == 3'd5) begin
            glyph = ASCII_CR;
        end else if (col == 3'd6) begin
            glyph = ASCII_LF;
        end else if (line_no[0]) begin
            glyph = col[0] ? ASCII_PLUS : ASCII_DASH;
        end else begin
            glyph = col[0] ? ASCII_PIPE : cell_glyph;
        end
    end

endmodule

// File: rtl/board_print_tx.sv
// Streams a 40-byte ASCII board rendering into a UART TX stage, one byte per
// send/busy handshake, from a snapshot taken when the print is accepted.
module board_print_tx
    import ttt_pkg::*;
#(
    parameter logic [7:0] EMPTY_CHAR = 8'h2E
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        print,
    input  logic [17:0] board,
    input  logic [3:0]  cursor,
    input  logic        turn,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done
);

    print_state_t     state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [17:0]      board_q;
    logic [3:0]       cursor_q;
    logic             turn_q;

    logic             accept;
    logic             step;
    logic             load_byte;
    logic [IDX_W-1:0] g_idx;
    logic [17:0]      g_board;
    logic [3:0]       g_cursor;
    logic             g_turn;
    logic [7:0]       g_byte;

    always_comb begin
        state_nxt = state;
        tx_send   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        load_byte = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (print) begin
                    accept    = 1'b1;
                    load_byte = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_send = 1'b1;
                if (!tx_busy) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (tx_busy) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        step      = 1'b1;
                        load_byte = 1'b1;
                        state_nxt = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // tx_data is loaded on entry to SEND, so the glyph lookup looks one step
    // ahead: the live inputs for byte 0, otherwise the snapshot at idx+1.
    always_comb begin
        if (state == ST_IDLE) begin
            g_idx    = '0;
            g_board  = board;
            g_cursor = cursor;
            g_turn   = turn;
        end else begin
            g_idx    = idx + IDX_W'(1);
            g_board  = board_q;
            g_cursor = cursor_q;
            g_turn   = turn_q;
        end
    end

    board_glyph #(
        .EMPTY_CHAR (EMPTY_CHAR)
    ) u_glyph (
        .idx    (g_idx),
        .board  (g_board),
        .cursor (g_cursor),
        .turn   (g_turn),
        .glyph  (g_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= ST_IDLE;
            idx      <= '0;
            board_q  <= '0;
            cursor_q <= '0;
            turn_q   <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx      <= '0;
                board_q  <= board;
                cursor_q <= cursor;
                turn_q   <= turn;
            end else if (step) begin
                idx <= idx + IDX_W'(1);
            end
            if (load_byte) tx_data <= g_byte;
        end
    end

endmodule

// File: tb/tb_board_print_tx.sv
// Scoreboard bench for board_print_tx: a UART model accepts bytes and pops
// the expected stream built from a string-level model of the board print.
module tb_board_print_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        print = 1'b0;
    logic [17:0] board = '0;
    logic [3:0]  cursor = 4'd15;
    logic        turn = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_bytes [0:63];
    int rx_cnt = 0;
    int done_cnt = 0;
    int lat_cycles = 0;
    int hold_cycles = 10;

    board_print_tx dut (
        .clk     (clk),
        .reset_n (reset_n),
        .print   (print),
        .board   (board),
        .cursor  (cursor),
        .turn    (turn),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_cell(input logic [17:0] b, input logic [3:0] c, input int i);
        logic [1:0] code;
        bit hit;
        code = b[2*i +: 2];
        hit  = (int'(c) == i);
        case (code)
            2'b00:   return hit ? 8'h5F : 8'h2E;
            2'b01:   return hit ? 8'h78 : 8'h58;
            2'b10:   return hit ? 8'h6F : 8'h4F;
            default: return 8'h3F;
        endcase
    endfunction

    task automatic push_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    endtask

    task automatic push_expected(input logic [17:0] b, input logic [3:0] c, input logic t);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(ref_cell(b, c, 3*r));
            push_str("|");
            exp_q.push_back(ref_cell(b, c, 3*r + 1));
            push_str("|");
            exp_q.push_back(ref_cell(b, c, 3*r + 2));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            if (r < 2) begin
                push_str("-+-+-");
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
        push_str("> ");
        exp_q.push_back(t ? 8'h4F : 8'h58);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // UART model and monitor: accepts a byte when send is high and busy low,
    // stays low for lat_cycles, then busy for hold_cycles.
    initial begin
        int phase;
        int cnt;
        logic [7:0] e;
        phase = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            case (phase)
                1: begin
                    if (cnt == 0) begin
                        tx_busy = 1'b1;
                        cnt = hold_cycles;
                        phase = 2;
                    end else begin
                        cnt--;
                    end
                end
                2: begin
                    cnt--;
                    if (cnt <= 0) begin
                        tx_busy = 1'b0;
                        phase = 0;
                    end
                end
                default: ;
            endcase
            if (phase == 0 && tx_send && !tx_busy) begin
                if (rx_cnt < 64) rx_bytes[rx_cnt] = tx_data;
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h with no byte expected at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", tx_data, e);
                end
                phase = 1;
                cnt = lat_cycles;
            end
        end
    end

    // mode 0: plain print; 1: re-pulse print and change board mid-print;
    // 2: assert reset during byte 20.
    task automatic run_print(input logic [17:0] b, input logic [3:0] c, input logic t, input int mode);
        logic [7:0] first;
        int d0;
        int guard;
        bit pulsed;
        exp_q.delete();
        push_expected(b, c, t);
        first = exp_q[0];
        rx_cnt = 0;
        d0 = done_cnt;
        board = b;
        cursor = c;
        turn = t;
        print = 1'b1;
        @(negedge clk); #1;
        print = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_send", tx_send, 1);
        check("accept_byte0", tx_data, first);
        guard = 0;
        pulsed = 0;
        while (done_cnt == d0 && guard < 3000) begin
            @(negedge clk); #1;
            guard++;
            if (mode == 1) begin
                if (rx_cnt >= 10 && !pulsed) begin
                    print = 1'b1;
                    pulsed = 1;
                end else begin
                    print = 1'b0;
                end
                if (rx_cnt >= 12) board = 18'($urandom);
            end
            if (mode == 2 && rx_cnt == 20) begin
                reset_n = 1'b0;
                #1;
                check("reset_send", tx_send, 0);
                check("reset_busy", busy, 0);
                check("reset_done", done, 0);
                exp_q.delete();
                repeat (2) @(negedge clk);
                #1;
                reset_n = 1'b1;
                return;
            end
        end
        print = 1'b0;
        check("done_timeout", (guard < 3000) ? 1 : 0, 1);
        @(negedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_once", done_cnt - d0, 1);
        check("byte_count", rx_cnt, 40);
        check("queue_empty", exp_q.size(), 0);
        repeat (30) @(negedge clk);
        #1;
        check("no_extra_bytes", rx_cnt, 40);
        check("no_extra_done", done_cnt - d0, 1);
    endtask

    initial begin
        #2;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_send", tx_send, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk); #1;

        lat_cycles = 0;
        hold_cycles = 10;
        run_print(18'h00000, 4'd15, 1'b0, 0);
        check("empty_b0", rx_bytes[0], 8'h2E);
        check("empty_b7", rx_bytes[7], 8'h2D);
        check("empty_b37", rx_bytes[37], 8'h58);

        run_print(18'h00021, 4'd0, 1'b0, 0);
        check("cursor_x_b0", rx_bytes[0], 8'h78);
        check("cell2_o_b4", rx_bytes[4], 8'h4F);

        run_print(18'h00000, 4'd4, 1'b1, 0);
        check("cursor_empty_b16", rx_bytes[16], 8'h5F);
        check("turn_o_b37", rx_bytes[37], 8'h4F);

        run_print(18'h26A19, 4'd7, 1'b0, 1);

        lat_cycles = 3;
        hold_cycles = 4;
        run_print(18'h3C9E6, 4'd2, 1'b1, 0);

        lat_cycles = 0;
        hold_cycles = 10;
        run_print(18'h12345, 4'd8, 1'b0, 2);
        run_print(18'h12345, 4'd8, 1'b0, 0);

        for (int n = 0; n < 4; n++) begin
            lat_cycles = $urandom_range(0, 3);
            hold_cycles = $urandom_range(1, 12);
            run_print(18'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
